// File: rtl/rf_pkg.sv
// Shared types and helpers for the reg_file register file.
// Configuration macro RF_BYPASS_EN is interpreted by rf_read_port.
package rf_pkg;

  localparam int RF_WIDTH_DEF = 32;
  localparam int RF_DEPTH_DEF = 32;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // DEPTH need not be a power of two, so the top of the address space can be unmapped
  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range check, busy masking and output register.
// With RF_BYPASS_EN defined, a same-cycle write to the read address is forwarded.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH_DEF,
  parameter int DEPTH  = RF_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic             in_range;
  logic [WIDTH-1:0] rdata_reg;
  logic [WIDTH-1:0] rdata_next;

  always_comb begin
    in_range   = addr_in_range(32'(raddr), 32'(DEPTH));
    rdata_next = '0;
    if (!busy && in_range) begin
`ifdef RF_BYPASS_EN
      if (wr_valid && (waddr == raddr)) begin
        rdata_next = wdata;
      end else begin
        rdata_next = mem_rdata;
      end
`else
      rdata_next = mem_rdata;
`endif
    end
  end

`ifndef RF_BYPASS_EN
  // Forwarding inputs are only consumed by the bypass build
  logic unused_bypass;
  assign unused_bypass = &{1'b0, wr_valid, waddr, wdata};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= rdata_next;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/reg_file.sv
// WIDTH x DEPTH register file: one write port, two registered read ports and a
// clear sequencer that zeroes all entries after reset or on clr_req. Macro: RF_BYPASS_EN.
module reg_file
  import rf_pkg::*;
#(
  parameter  int WIDTH  = RF_WIDTH_DEF,
  parameter  int DEPTH  = RF_DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;

  logic              wr_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RF_CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RF_IDLE: begin
        if (clr_req) begin
          state_next = RF_CLEAR;
          cnt_next   = '0;
        end
      end
      RF_CLEAR: begin
        if (cnt_reg == LAST_ADDR) begin
          state_next = RF_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + ADDR_W'(1);
        end
      end
      default: begin
        state_next = RF_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The sweep owns the write port while busy; a clear request drops a coincident write
  always_comb begin
    busy      = (state_reg == RF_CLEAR);
    wr_valid  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (state_reg == RF_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_reg;
      mem_wdata = '0;
    end else if (we && !clr_req && addr_in_range(32'(waddr), 32'(DEPTH))) begin
      wr_valid = 1'b1;
      mem_we   = 1'b1;
    end
  end

  // Storage carries no reset; the clear sweep initialises it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic              re_v    [2];
  logic [ADDR_W-1:0] raddr_v [2];
  logic [WIDTH-1:0]  rdata_v [2];

  assign re_v[0]    = re_a;
  assign re_v[1]    = re_b;
  assign raddr_v[0] = raddr_a;
  assign raddr_v[1] = raddr_b;
  assign rdata_a    = rdata_v[0];
  assign rdata_b    = rdata_v[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      rf_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
      ) u_rport (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .re       (re_v[gi]),
        .raddr    (raddr_v[gi]),
        .mem_rdata(mem[raddr_v[gi]]),
        .wr_valid (wr_valid),
        .waddr    (waddr),
        .wdata    (wdata),
        .rdata    (rdata_v[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (32x32 and 32x20 instances).
// Expected values for the same-cycle case follow RF_BYPASS_EN.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        clr_req = 1'b0, we = 1'b0, re_a = 1'b0, re_b = 1'b0;
  logic [4:0]  waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic [31:0] rdata_a, rdata_b;

  logic        clr_req_20 = 1'b0, we_20 = 1'b0, re_a_20 = 1'b0, re_b_20 = 1'b0;
  logic [4:0]  waddr_20 = '0, raddr_a_20 = '0, raddr_b_20 = '0;
  logic [31:0] wdata_20 = '0;
  logic        busy_20;
  logic [31:0] rdata_a_20, rdata_b_20;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
  );

  reg_file #(.WIDTH(32), .DEPTH(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req_20), .busy(busy_20),
    .we(we_20), .waddr(waddr_20), .wdata(wdata_20),
    .re_a(re_a_20), .raddr_a(raddr_a_20), .rdata_a(rdata_a_20),
    .re_b(re_b_20), .raddr_b(raddr_b_20), .rdata_b(rdata_b_20)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n32, n20;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rdata_a=%h rdata_b=%h, want busy=1 rdata=0", busy, rdata_a, rdata_b);
    end
    rst_n = 1'b1;
    n32 = 0;
    n20 = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b1) n32++;
      if (busy_20 === 1'b1) n20++;
      tick();
    end
    checks++;
    if (n32 !== 32) begin
      errors++;
      $display("FAIL reset_sweep_len32: busy cycles=%0d, want 32", n32);
    end
    checks++;
    if (n20 !== 20) begin
      errors++;
      $display("FAIL reset_sweep_len20: busy cycles=%0d, want 20", n20);
    end
    for (int i = 0; i < 32; i++) begin
      re_a = 1'b1; raddr_a = 5'(i);
      re_b = 1'b1; raddr_b = 5'(31 - i);
      tick();
      checks++;
      if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
        errors++;
        $display("FAIL reset_zero[%0d]: rdata_a=%h rdata_b=%h, want 0", i, rdata_a, rdata_b);
      end
    end
    re_a = 1'b0; re_b = 1'b0;
    $display("test_reset: busy32=%0d busy20=%0d cycles, 32 entries read", n32, n20);
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    re_a = 1'b1; raddr_a = 5'd5;
    re_b = 1'b1; raddr_b = 5'd5;
    tick();
    checks++;
    if (rdata_a !== 32'hDEADBEEF || rdata_b !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read: rdata_a=%h rdata_b=%h, want deadbeef", rdata_a, rdata_b);
    end
    re_a = 1'b0; re_b = 1'b0; raddr_a = 5'd0; raddr_b = 5'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rdata_a !== 32'hDEADBEEF || rdata_b !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL hold[%0d]: rdata_a=%h rdata_b=%h, want deadbeef", i, rdata_a, rdata_b);
      end
    end
    $display("test_write_read: addr 5 -> %h / %h", rdata_a, rdata_b);
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_first;
`ifdef RF_BYPASS_EN
    exp_first = 32'h12345678;
`else
    exp_first = 32'h0;
`endif
    we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
    re_a = 1'b1; raddr_a = 5'd7;
    tick();
    we = 1'b0;
    checks++;
    if (rdata_a !== exp_first) begin
      errors++;
      $display("FAIL same_cycle: rdata_a=%h, want %h", rdata_a, exp_first);
    end
    tick();
    checks++;
    if (rdata_a !== 32'h12345678) begin
      errors++;
      $display("FAIL same_cycle_repeat: rdata_a=%h, want 12345678", rdata_a);
    end
    re_a = 1'b0;
    $display("test_same_cycle: first=%h repeat=%h", exp_first, rdata_a);
  endtask

  task automatic test_clr_precedence();
    int n;
    clr_req = 1'b1;
    we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
    re_a = 1'b1; raddr_a = 5'd5;
    tick();
    clr_req = 1'b0;
    checks++;
    if (rdata_a !== 32'hDEADBEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_req_cycle: rdata_a=%h busy=%b, want deadbeef busy=1", rdata_a, busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
      re_a = 1'b1; raddr_a = 5'd5;
      tick();
      n++;
      checks++;
      if (rdata_a !== 32'h0) begin
        errors++;
        $display("FAIL busy_read[%0d]: rdata_a=%h, want 0", n, rdata_a);
      end
    end
    we = 1'b0;
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL clr_sweep_len: busy cycles=%0d, want 32", n);
    end
    raddr_a = 5'd3; re_b = 1'b1; raddr_b = 5'd5;
    tick();
    checks++;
    if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
      errors++;
      $display("FAIL clr_result: entry3=%h entry5=%h, want 0", rdata_a, rdata_b);
    end
    re_a = 1'b0; re_b = 1'b0;
    $display("test_clr_precedence: sweep %0d cycles, entry3=%h", n, rdata_a);
  endtask

  task automatic test_depth20();
    we_20 = 1'b1; waddr_20 = 5'd25; wdata_20 = 32'hAA;
    tick();
    waddr_20 = 5'd19; wdata_20 = 32'h55;
    tick();
    we_20 = 1'b0;
    re_a_20 = 1'b1; raddr_a_20 = 5'd25;
    re_b_20 = 1'b1; raddr_b_20 = 5'd19;
    tick();
    checks++;
    if (rdata_a_20 !== 32'h0) begin
      errors++;
      $display("FAIL d20_oob_read: rdata_a=%h, want 0", rdata_a_20);
    end
    checks++;
    if (rdata_b_20 !== 32'h55) begin
      errors++;
      $display("FAIL d20_last_entry: rdata_b=%h, want 55", rdata_b_20);
    end
    re_a_20 = 1'b0; re_b_20 = 1'b0;
    $display("test_depth20: addr25=%h addr19=%h", rdata_a_20, rdata_b_20);
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    we = 1'b1; waddr = 5'd1; wdata = 32'h5A5A5A5A;
    tick();
    we = 1'b0;
    re_a = 1'b1; raddr_a = 5'd1; re_b = 1'b1; raddr_b = 5'd1;
    tick();
    re_a = 1'b0; re_b = 1'b0;
    checks++;
    if (rdata_a !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL pre_reset_read: rdata_a=%h, want 5a5a5a5a", rdata_a);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_busy: busy=%b, want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b rdata_a=%h rdata_b=%h, want 1/0/0", busy, rdata_a, rdata_b);
    end
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL restart_sweep_len: busy cycles=%0d, want 32", n);
    end
    re_a = 1'b1; raddr_a = 5'd1;
    tick();
    re_a = 1'b0;
    checks++;
    if (rdata_a !== 32'h0) begin
      errors++;
      $display("FAIL restart_cleared: entry1=%h, want 0", rdata_a);
    end
    $display("test_reset_mid_sweep: restart sweep %0d cycles, entry1=%h", n, rdata_a);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_cycle();
    test_clr_precedence();
    test_depth20();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-entry register file for the ALU datapath, with one write port and two registered read ports (A and B) feeding the operand latches. It generalises the single 32-bit write-enabled register to WIDTH x DEPTH storage. A hardware clear sequencer zeroes every entry after reset or on request, so no entry ever needs a per-bit reset. Optional write-to-read bypass provides same-cycle forwarding.

## Interface
- WIDTH, 32, data width in bits (>=1)
- DEPTH, 32, number of entries (>=2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- clr_req  input  1  single-cycle request to zero all entries
- busy  output  1  clear sweep in progress
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- re_a / re_b  input  1  read enable, ports A/B
- raddr_a / raddr_b  input  ADDR_W  read address, ports A/B
- rdata_a / rdata_b  output  WIDTH  registered read data, ports A/B

## Operation
- FSM has two states, IDLE and CLEAR. It also holds a sweep counter `cnt` of ADDR_W bits.
- rst_n low: state=CLEAR, cnt=0, busy=1, rdata_a=rdata_b=0. The storage array itself is not reset.
- CLEAR: each cycle writes 0 to entry cnt, then cnt++. When cnt==DEPTH-1 is written, the next state is IDLE and cnt=0.
- IDLE: when clr_req=1, the next state is CLEAR. busy rises on the following edge.
- Precedence of clr_req and we when both are high in the same IDLE cycle:
  - clear wins; the write is dropped;
  - reads in that cycle are serviced normally.
- busy=1 in CLEAR.
  - we is ignored.
  - clr_req is ignored.
  - Enabled reads load 0.
- Write: when we=1, state=IDLE and waddr<DEPTH, entry waddr <= wdata.
- waddr>=DEPTH: the write is silently dropped.
- Read: when re_x=1, rdata_x <= entry raddr_x. The value is 0 if raddr_x>=DEPTH or busy=1.
- re_x=0: rdata_x holds its previous value.
- Ports A and B are independent. Both may read the same address in the same cycle.

## Timing
- Read latency is 1 cycle. Address presented at edge N gives data on rdata_x after edge N+1 and stable through cycle N+1.
- Write visibility: data written at edge N is returned by any read issued at cycle N+1 or later.
- Same-cycle write and read of the same address: see Configuration.
- Clear timing:
  - clear after reset: busy=1 for exactly DEPTH cycles after rst_n deasserts;
  - clear on request: busy=1 for exactly DEPTH cycles, starting the cycle after clr_req.
- First usable write or read is the cycle busy is sampled 0.
- rst_n asserted mid-sweep or mid-operation:
  - immediate return to the reset values;
  - the sweep restarts from entry 0 after deassertion.
- No backpressure: every enabled access completes in one cycle.

## Configuration
- RF_BYPASS_EN defined:
  - a read of address R in the same cycle as a valid write to R (we=1, IDLE, waddr==R<DEPTH) loads wdata into rdata_x;
  - this applies per port independently.
- RF_BYPASS_EN undefined:
  - the same case loads the old entry value;
  - the new value is visible from the next cycle on.
- All other behaviour is identical in both builds.

## Structure
- Shared package rf_pkg:
  - rf_state_e enum (RF_IDLE, RF_CLEAR);
  - default WIDTH/DEPTH localparams;
  - an address-in-range helper function.
- Sub-module rf_read_port, instantiated twice (A, B). It contains the range check, busy masking, bypass compare under RF_BYPASS_EN, and the output register.
- Top level holds the storage array, the write decode and the clear FSM/counter.

## Test plan
- Reset then sweep (WIDTH=32, DEPTH=32):
  - release rst_n -> busy=1 for 32 cycles then 0;
  - afterwards, reads of all 32 entries -> 0x00000000.
- Basic write then read:
  - write 0xDEADBEEF to addr 5;
  - next cycle read A=5 and B=5 -> both rdata = 0xDEADBEEF one cycle later;
  - re low for 3 cycles -> value held.
- Same-cycle write and read of addr 7 with wdata=0x12345678 (old value 0):
  - RF_BYPASS_EN build -> rdata_a=0x12345678;
  - non-bypass build -> rdata_a=0, then 0x12345678 on a repeat read.
- clr_req with we=1 (waddr=3, wdata=0xFF) in the same cycle:
  - write dropped; busy for 32 cycles;
  - writes and reads during busy: writes dropped, reads return 0;
  - after busy falls, entry 3 reads 0.
- DEPTH=20:
  - write 0xAA to addr 25 -> dropped;
  - read addr 25 -> 0;
  - read addr 19 after writing 0x55 -> 0x55.
- rst_n pulsed at sweep cycle 10:
  - rdata=0 and busy=1 during reset;
  - full 32-cycle sweep restarts after release.
